// File: rtl/counter_multimode.sv
// Multimode counter: prescaler, parallel load, up/down, and
// wrap / saturate / one-shot / ping-pong end-of-range behaviour.
// Produces a one-cycle terminal-count pulse and a sticky one-shot done flag.
module counter_multimode #(
  parameter int unsigned       WIDTH    = 8,
  parameter logic [WIDTH-1:0]  MAX      = WIDTH'(170),
  parameter int unsigned       PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             syncRst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_PINGPONG = 2'b11
  } mode_e;

  localparam int unsigned    PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             pp_q, pp_d;      // ping-pong direction: 0 = up, 1 = down

  mode_e            mode_s;
  logic             up;
  logic             at_bound;
  logic             step;
  logic [WIDTH-1:0] load_clamped;

  assign mode_s       = mode_e'(mode);
  assign up           = (mode_s == MODE_PINGPONG) ? ~pp_q : ~dir;
  assign at_bound     = up ? (counter_q == MAX) : (counter_q == '0);
  assign load_clamped = (load_val > MAX) ? MAX : load_val;

  // Next-state: syncRst beats load beats a prescaled step.
  always_comb begin
    counter_d = counter_q;
    pre_d     = pre_q;
    tc_d      = 1'b0;
    done_d    = done_q;
    pp_d      = pp_q;
    step      = 1'b0;

    if (syncRst) begin
      counter_d = '0;
      pre_d     = '0;
      done_d    = 1'b0;
      pp_d      = 1'b0;
    end else if (load) begin
      counter_d = load_clamped;
      pre_d     = '0;
      done_d    = 1'b0;
    end else if (en && !done_q) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end

    if (step) begin
      if (!at_bound) begin
        counter_d = up ? (counter_q + WIDTH'(1)) : (counter_q - WIDTH'(1));
      end else begin
        tc_d = 1'b1;
        unique case (mode_s)
          MODE_WRAP:     counter_d = up ? '0 : MAX;
          MODE_SAT:      counter_d = counter_q;
          MODE_ONESHOT:  done_d    = 1'b1;
          MODE_PINGPONG: begin
            pp_d      = ~pp_q;
            counter_d = up ? (counter_q - WIDTH'(1)) : (counter_q + WIDTH'(1));
          end
          default:       counter_d = counter_q;
        endcase
      end
    end

    // Ping-pong direction only survives while staying in ping-pong mode.
    if (mode_s != MODE_PINGPONG) begin
      pp_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter_q <= '0;
      pre_q     <= '0;
      tc_q      <= 1'b0;
      done_q    <= 1'b0;
      pp_q      <= 1'b0;
    end else begin
      counter_q <= counter_d;
      pre_q     <= pre_d;
      tc_q      <= tc_d;
      done_q    <= done_d;
      pp_q      <= pp_d;
    end
  end

  assign counter = counter_q;
  assign tc      = tc_q;
  assign done    = done_q;

endmodule

// File: tb/tb_counter_multimode.sv
// Bench for counter_multimode: PRESCALE=1 and PRESCALE=4 instances share stimulus;
// a behavioural model feeds a scoreboard queue, plus fixed-value checks.
module tb_counter_multimode;

  localparam logic [7:0] MAXV = 8'hAA;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, sync_rst, load, dir;
  logic [7:0] load_val;
  logic [1:0] mode;
  logic [7:0] cnt1, cnt4;
  logic       tc1, tc4, done1, done4;

  always #5 clk = ~clk;

  counter_multimode #(.WIDTH(8), .MAX(8'hAA), .PRESCALE(1)) u_p1 (
    .clk(clk), .rst(rst_n), .en(en), .syncRst(sync_rst), .load(load),
    .load_val(load_val), .dir(dir), .mode(mode),
    .counter(cnt1), .tc(tc1), .done(done1)
  );

  counter_multimode #(.WIDTH(8), .MAX(8'hAA), .PRESCALE(4)) u_p4 (
    .clk(clk), .rst(rst_n), .en(en), .syncRst(sync_rst), .load(load),
    .load_val(load_val), .dir(dir), .mode(mode),
    .counter(cnt4), .tc(tc4), .done(done4)
  );

  typedef struct packed {
    logic [7:0] c1; logic t1; logic d1;
    logic [7:0] c4; logic t4; logic d4;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] m_cnt  [2];
  logic       m_tc   [2];
  logic       m_done [2];
  logic       m_pp   [2];
  int         m_pre  [2];
  int         ps     [2] = '{1, 4};

  // Behavioural reference: clears model state on reset.
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 8'h00; m_tc[k] = 1'b0; m_done[k] = 1'b0; m_pp[k] = 1'b0; m_pre[k] = 0;
    end
    sb.delete();
  endtask

  // Behavioural reference: one clock edge with the currently driven inputs.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic up, bnd, stp;
      m_tc[k] = 1'b0;
      stp = 1'b0;
      if (sync_rst) begin
        m_cnt[k] = 8'h00; m_done[k] = 1'b0; m_pp[k] = 1'b0; m_pre[k] = 0;
      end else if (load) begin
        m_cnt[k] = (load_val > MAXV) ? MAXV : load_val;
        m_pre[k] = 0; m_done[k] = 1'b0;
      end else if (en && !m_done[k]) begin
        if (m_pre[k] == ps[k] - 1) begin stp = 1'b1; m_pre[k] = 0; end
        else m_pre[k] = m_pre[k] + 1;
      end
      if (stp) begin
        up  = (mode == 2'd3) ? !m_pp[k] : !dir;
        bnd = up ? (m_cnt[k] == MAXV) : (m_cnt[k] == 8'h00);
        if (!bnd) m_cnt[k] = up ? m_cnt[k] + 8'd1 : m_cnt[k] - 8'd1;
        else begin
          m_tc[k] = 1'b1;
          case (mode)
            2'd0: m_cnt[k] = up ? 8'h00 : MAXV;
            2'd1: ;
            2'd2: m_done[k] = 1'b1;
            default: begin
              m_pp[k]  = !m_pp[k];
              m_cnt[k] = up ? (MAXV - 8'd1) : 8'd1;
            end
          endcase
        end
      end
      if (mode != 2'd3) m_pp[k] = 1'b0;
    end
  endtask

  // Push the model's expectation for the coming edge, then advance past it.
  task automatic tick();
    exp_t e;
    model_step();
    e.c1 = m_cnt[0]; e.t1 = m_tc[0]; e.d1 = m_done[0];
    e.c4 = m_cnt[1]; e.t4 = m_tc[1]; e.d4 = m_done[1];
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; sync_rst = 1'b0; load = 1'b0; load_val = 8'h00; dir = 1'b0; mode = 2'd0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    idle_inputs();
    #2;
    checks++;
    if ({cnt1, tc1, done1, cnt4, tc4, done4} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state p1 c=%h tc=%b d=%b p4 c=%h tc=%b d=%b exp all 0",
               cnt1, tc1, done1, cnt4, tc4, done4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if ({cnt1, tc1, done1, cnt4, tc4, done4} !== e) begin
        errors++;
        $display("FAIL reset_idle got %h exp %h", {cnt1, tc1, done1, cnt4, tc4, done4}, e);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    sync_rst = 1'b1; tick(); void'(sb.pop_front()); sync_rst = 1'b0;
    mode = 2'd0; dir = 1'b0; en = 1'b1;
    for (int i = 1; i <= 172; i++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if ({cnt1, tc1, done1, cnt4, tc4, done4} !== e) begin
        errors++;
        $display("FAIL wrap_sb step %0d got %h exp %h", i, {cnt1, tc1, done1, cnt4, tc4, done4}, e);
      end
      if (i == 170 || i == 171 || i == 172) begin
        checks++;
        if ({cnt1, tc1} !== ((i == 170) ? {MAXV, 1'b0} : (i == 171) ? {8'h00, 1'b1} : {8'h01, 1'b0})) begin
          errors++;
          $display("FAIL wrap_edge step %0d got c=%h tc=%b", i, cnt1, tc1);
        end
      end
    end
  endtask

  task automatic test_prescale();
    exp_t e;
    logic en_pat [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
    sync_rst = 1'b1; tick(); void'(sb.pop_front()); sync_rst = 1'b0;
    mode = 2'd0; dir = 1'b0;
    for (int i = 0; i < 11; i++) begin
      en = en_pat[i];
      tick();
      e = sb.pop_front();
      checks++;
      if ({cnt1, tc1, done1, cnt4, tc4, done4} !== e) begin
        errors++;
        $display("FAIL prescale_sb cyc %0d got %h exp %h", i, {cnt1, tc1, done1, cnt4, tc4, done4}, e);
      end
      if (i == 2 || i == 3 || i == 9 || i == 10) begin
        checks++;
        if (cnt4 !== ((i == 2) ? 8'h00 : (i == 10) ? 8'h02 : 8'h01)) begin
          errors++;
          $display("FAIL prescale_step cyc %0d got %h", i, cnt4);
        end
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    logic [7:0] exp_c [4] = '{8'h01, 8'h00, 8'h00, 8'h00};
    logic       exp_t_ [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    mode = 2'd1; dir = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'h02;
    tick(); void'(sb.pop_front());
    load = 1'b0;
    checks++;
    if (cnt1 !== 8'h02) begin errors++; $display("FAIL sat_load got %h exp 02", cnt1); end
    for (int i = 0; i < 4; i++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if ({cnt1, tc1, done1, cnt4, tc4, done4} !== e) begin
        errors++;
        $display("FAIL sat_sb cyc %0d got %h exp %h", i, {cnt1, tc1, done1, cnt4, tc4, done4}, e);
      end
      checks++;
      if ({cnt1, tc1} !== {exp_c[i], exp_t_[i]}) begin
        errors++;
        $display("FAIL sat_seq cyc %0d got c=%h tc=%b exp c=%h tc=%b", i, cnt1, tc1, exp_c[i], exp_t_[i]);
      end
    end
    load = 1'b1; load_val = 8'hFF;
    tick(); void'(sb.pop_front());
    load = 1'b0;
    checks++;
    if ({cnt1, cnt4} !== {MAXV, MAXV}) begin
      errors++;
      $display("FAIL load_clamp got p1=%h p4=%h exp aa", cnt1, cnt4);
    end
  endtask

  task automatic test_oneshot();
    exp_t e;
    logic [7:0] exp_c [5] = '{8'hA9, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    logic       exp_t_ [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_d [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    mode = 2'd2; dir = 1'b0; en = 1'b1; load = 1'b1; load_val = 8'hA8;
    tick(); void'(sb.pop_front());
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if ({cnt1, tc1, done1, cnt4, tc4, done4} !== e) begin
        errors++;
        $display("FAIL oneshot_sb cyc %0d got %h exp %h", i, {cnt1, tc1, done1, cnt4, tc4, done4}, e);
      end
      checks++;
      if ({cnt1, tc1, done1} !== {exp_c[i], exp_t_[i], exp_d[i]}) begin
        errors++;
        $display("FAIL oneshot_seq cyc %0d got c=%h tc=%b d=%b exp c=%h tc=%b d=%b",
                 i, cnt1, tc1, done1, exp_c[i], exp_t_[i], exp_d[i]);
      end
    end
    sync_rst = 1'b1;
    tick(); void'(sb.pop_front());
    sync_rst = 1'b0;
    checks++;
    if ({cnt1, done1} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL oneshot_clear got c=%h d=%b exp c=00 d=0", cnt1, done1);
    end
  endtask

  task automatic test_pingpong();
    exp_t e;
    mode = 2'd3; en = 1'b1; load = 1'b1; load_val = 8'hA9;
    tick(); void'(sb.pop_front());
    load = 1'b0;
    for (int i = 1; i <= 172; i++) begin
      dir = 1'($urandom_range(0, 1));
      tick();
      e = sb.pop_front();
      checks++;
      if ({cnt1, tc1, done1, cnt4, tc4, done4} !== e) begin
        errors++;
        $display("FAIL pingpong_sb step %0d got %h exp %h", i, {cnt1, tc1, done1, cnt4, tc4, done4}, e);
      end
      if (i == 1 || i == 2 || i == 171 || i == 172) begin
        checks++;
        if ({cnt1, tc1} !== ((i == 1) ? {8'hAA, 1'b0} : (i == 2) ? {8'hA9, 1'b1} :
                             (i == 171) ? {8'h00, 1'b0} : {8'h01, 1'b1})) begin
          errors++;
          $display("FAIL pingpong_turn step %0d got c=%h tc=%b", i, cnt1, tc1);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    mode = 2'd0; dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); void'(sb.pop_front()); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cnt1, tc1, done1, cnt4, tc4, done4} !== 20'h0) begin
      errors++;
      $display("FAIL async_reset got p1 c=%h tc=%b d=%b p4 c=%h tc=%b d=%b exp all 0",
               cnt1, tc1, done1, cnt4, tc4, done4);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin tick(); void'(sb.pop_front()); end
    load = 1'b1; sync_rst = 1'b1; load_val = 8'h55;
    tick();
    e = sb.pop_front();
    load = 1'b0; sync_rst = 1'b0;
    checks++;
    if ({cnt1, tc1, done1, cnt4, tc4, done4} !== e || cnt1 !== 8'h00) begin
      errors++;
      $display("FAIL sync_over_load got p1=%h p4=%h exp %h", cnt1, cnt4, e);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      sync_rst = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 19) == 0);
      load_val = 8'($urandom_range(0, 255));
      dir      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      tick();
      e = sb.pop_front();
      checks++;
      if ({cnt1, tc1, done1, cnt4, tc4, done4} !== e) begin
        errors++;
        $display("FAIL random_sb cyc %0d got %h exp %h", i, {cnt1, tc1, done1, cnt4, tc4, done4}, e);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_prescale();
    test_saturate();
    test_oneshot();
    test_pingpong();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
